// File: rtl/data_mem_access_ctrl.sv
// MEM-stage access controller in front of the 512x8 data RAM: alignment check,
// doubleword split into two big-endian word transfers, one-cycle response pulse.
//
// state | meaning
// IDLE  | ready for a request, RAM idle
// ACC0  | first (or only) RAM access
// ACC1  | second word of a doubleword, at addr+4
// RESP  | RespValid pulse with assembled load data
// TRAP  | RespValid + AlignTrap pulse, no RAM access
module data_mem_access_ctrl #(
  parameter int ADDR_W = 9,
  parameter int DW     = 32
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              ReqValid,
  output logic              ReqReady,
  input  logic              ReqWrite,
  input  logic [1:0]        ReqSize,
  input  logic              ReqSignExt,
  input  logic [ADDR_W-1:0] ReqAddr,
  input  logic [2*DW-1:0]   ReqData,
  output logic              RespValid,
  output logic [2*DW-1:0]   RespData,
  output logic              AlignTrap,
  output logic              MemEnable,
  output logic              MemReadWrite,
  output logic              MemSignExtend,
  output logic [ADDR_W-1:0] MemAddress,
  output logic [DW-1:0]     MemDataIn,
  output logic [1:0]        MemSize,
  input  logic [DW-1:0]     MemDataOut
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ACC0 = 3'd1;
  localparam logic [2:0] S_ACC1 = 3'd2;
  localparam logic [2:0] S_RESP = 3'd3;
  localparam logic [2:0] S_TRAP = 3'd4;

  logic [2:0]        r_state;
  logic              r_out_of_reset;
  logic              r_write;
  logic [1:0]        r_size;
  logic              r_sext;
  logic [ADDR_W-1:0] r_addr;
  logic [2*DW-1:0]   r_data;
  logic [DW-1:0]     r_word0;
  logic [DW-1:0]     r_word1;

  logic w_accept;
  logic w_misaligned;
  logic w_dbl;

  always_comb begin
    w_misaligned = 1'b0;
    case (ReqSize)
      2'b01:   w_misaligned = ReqAddr[0];
      2'b10:   w_misaligned = |ReqAddr[1:0];
      2'b11:   w_misaligned = |ReqAddr[2:0];
      default: w_misaligned = 1'b0;
    endcase
  end

  // ReqReady stays low during the first cycle after reset release.
  assign ReqReady = (r_state == S_IDLE) && r_out_of_reset;
  assign w_accept = ReqValid && ReqReady;
  assign w_dbl    = (r_size == 2'b11);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state        <= S_IDLE;
      r_out_of_reset <= 1'b0;
      r_write        <= 1'b0;
      r_size         <= 2'b00;
      r_sext         <= 1'b0;
      r_addr         <= '0;
      r_data         <= '0;
      r_word0        <= '0;
      r_word1        <= '0;
    end else begin
      r_out_of_reset <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_write <= ReqWrite;
            r_size  <= ReqSize;
            r_sext  <= ReqSignExt;
            r_addr  <= ReqAddr;
            r_data  <= ReqData;
            r_word0 <= '0;
            r_word1 <= '0;
            r_state <= w_misaligned ? S_TRAP : S_ACC0;
          end
        end
        S_ACC0: begin
          r_word0 <= MemDataOut;
          r_state <= w_dbl ? S_ACC1 : S_RESP;
        end
        S_ACC1: begin
          r_word1 <= MemDataOut;
          r_state <= S_RESP;
        end
        S_RESP:  r_state <= S_IDLE;
        S_TRAP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    MemEnable     = 1'b0;
    MemReadWrite  = 1'b0;
    MemSignExtend = 1'b0;
    MemAddress    = '0;
    MemDataIn     = '0;
    MemSize       = 2'b00;
    RespValid     = 1'b0;
    RespData      = '0;
    AlignTrap     = 1'b0;
    case (r_state)
      S_ACC0: begin
        MemEnable     = 1'b1;
        MemReadWrite  = r_write;
        MemAddress    = r_addr;
        MemSize       = w_dbl ? 2'b10 : r_size;
        MemSignExtend = r_size[1] ? 1'b0 : r_sext;
        MemDataIn     = w_dbl ? r_data[2*DW-1:DW] : r_data[DW-1:0];
      end
      S_ACC1: begin
        MemEnable    = 1'b1;
        MemReadWrite = r_write;
        MemAddress   = r_addr + ADDR_W'(4);
        MemSize      = 2'b10;
        MemDataIn    = r_data[DW-1:0];
      end
      S_RESP: begin
        RespValid = 1'b1;
        if (!r_write)
          RespData = w_dbl ? {r_word0, r_word1} : {{DW{1'b0}}, r_word0};
      end
      S_TRAP: begin
        RespValid = 1'b1;
        AlignTrap = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/data_mem_access_ctrl.md
Name: data_mem_access_ctrl

Overview:
- Memory-stage access controller that sits directly upstream of the 512x8 data RAM (ram_512x8).
- Accepts one load/store request at a time from the pipeline MEM stage and checks alignment.
- Drives the RAM's Enable/ReadWrite/SignExtend/Address/DataIn/Size port set.
- Splits SPARC doubleword accesses (LDD/STD) into two big-endian word transfers and returns the assembled result with a one-cycle response pulse.

Parameters:
- ADDR_W, 9: RAM byte-address width.
- DW, 32: RAM data-port width; doubleword is 2*DW.

Ports:
- Clk  input  1  rising-edge clock.
- Reset_n  input  1  reset; asynchronous, active-low.
- ReqValid  input  1  request present.
- ReqReady  output  1  controller can accept; high only in IDLE.
- ReqWrite  input  1  1=store, 0=load.
- ReqSize  input  2  00 byte, 01 halfword, 10 word, 11 doubleword.
- ReqSignExt  input  1  sign-extend byte/halfword loads.
- ReqAddr  input  ADDR_W  byte address.
- ReqData  input  2*DW  store data; [31:0] used for sizes 00/01/10; [63:32] is the first (low-address) word for size 11.
- RespValid  output  1  one-cycle completion pulse.
- RespData  output  2*DW  load result.
- AlignTrap  output  1  pulses together with RespValid on a misaligned request.
- MemEnable  output  1  to RAM Enable.
- MemReadWrite  output  1  to RAM ReadWrite (1=write).
- MemSignExtend  output  1  to RAM SignExtend.
- MemAddress  output  ADDR_W  to RAM Address.
- MemDataIn  output  DW  to RAM DataIn.
- MemSize  output  2  to RAM Size.
- MemDataOut  input  DW  from RAM DataOut; combinational read.

Behaviour:
- Reset (async, Reset_n=0):
  - State=IDLE.
  - All outputs 0, including ReqReady.
  - Request capture registers cleared.
  - ReqReady rises on the first Clk edge after Reset_n deasserts.
- Reset mid-operation aborts immediately:
  - MemEnable drops asynchronously.
  - No RespValid is issued.
  - Partial doubleword data is discarded.
  - A store already in progress may have written its first word; no rollback.
- FSM states: IDLE, ACC0, ACC1, RESP, TRAP.
- IDLE:
  - ReqReady=1, all Mem* outputs 0.
  - On ReqValid: capture ReqWrite/ReqSize/ReqSignExt/ReqAddr/ReqData.
  - Go to TRAP if misaligned, else ACC0.
- Alignment rules:
  - Halfword needs Addr[0]=0.
  - Word needs Addr[1:0]=0.
  - Doubleword needs Addr[2:0]=0.
  - Byte is always aligned.
- ACC0:
  - MemEnable=1; MemReadWrite=captured Write; MemAddress=captured Addr.
  - MemSize=captured Size for 00/01/10; 10 for doubleword.
  - MemSignExtend=captured SignExt for sizes 00/01; 0 otherwise.
  - MemDataIn=ReqData[31:0], or ReqData[63:32] for a doubleword.
  - Loads register MemDataOut at the end of the cycle.
  - Next state: ACC1 if doubleword, else RESP.
- ACC1 (doubleword only):
  - MemAddress=Addr+4, MemSize=10, MemDataIn=ReqData[31:0].
  - A load captures this second word. Next state: RESP.
- RESP:
  - RespValid=1 for exactly one cycle, MemEnable=0, then IDLE.
  - Non-double load: RespData={32'h0, word0}.
  - Doubleword load: RespData={word0, word1}, big-endian.
  - Store: RespData=0.
- TRAP:
  - RespValid=1 and AlignTrap=1 for one cycle, RespData=0.
  - No RAM access: MemEnable stays 0 throughout. Then IDLE.
- Latency from the accept edge:
  - Single access: RespValid 2 cycles later.
  - Doubleword: 3 cycles later.
  - Trap: 1 cycle later.
- Throughput: ReqReady is low from the cycle after accept until the state returns to IDLE. A ReqValid held high through RESP is accepted in the following IDLE cycle, so there is no back-to-back accept in RESP.
- Address wrap: the highest aligned double (0x1F8) makes its second access at 0x1FC, so no 9-bit overflow is possible. Addr+4 is computed modulo 2^ADDR_W regardless.
- RespValid has no backpressure; the consumer must take it in the pulse cycle.

Test Plan:
1. Preload RAM bytes 0..7 = 8A 12 34 56 9A BC DE F0. Byte load, signext=1, addr 0 -> RespValid 2 cycles after accept, RespData=0x00000000_FFFFFF8A. Same request with signext=0 -> 0x0000008A.
2. Halfword load at addr 2, signext=0 -> RespData low word=0x00003456. Word load at addr 4 -> 0x9ABCDEF0.
3. Doubleword load at addr 0 -> MemAddress 0 then 4 in consecutive cycles, MemSize=10 both cycles; RespData=0x8A123456_9ABCDEF0, RespValid 3 cycles after accept.
4. Doubleword store at 8 with ReqData=0x11223344_55667788, then word loads at 8 and 12 -> 0x11223344 and 0x55667788. Byte store 0xA6 at 0 then word load at 0 -> 0xA6123456.
5. Misaligned word load at addr 2 and doubleword at addr 4 -> RespValid=AlignTrap=1 one cycle after accept, MemEnable never asserted, RAM contents unchanged.
6. Assert Reset_n=0 during ACC1 of a doubleword load -> MemEnable and all outputs 0 immediately, no RespValid. After release, ReqReady=1 on the next edge and a fresh word load at 0 returns correct data.
